// File: rtl/decode_in_buffer.sv
// -----------------------------------------------------------------------------
// decode_in_buffer
//
// Purpose:
//   Small circular FIFO between fetch and decode. Each entry holds a fetched
//   instruction together with its next-PC. Decode sees the head entry and
//   consumes it whenever it is not stalled. A flush (branch/redirect) discards
//   everything buffered and drops the same-cycle input.
//
// Parameters:
//   IW     instruction width in bits
//   AW     NPC width in bits
//   DEPTH  number of entries (power of 2, minimum 2)
//   CW     occupancy count width, derived from DEPTH
//
// Ports:
//   clock          sole clock, all state updates on the rising edge
//   reset          synchronous, active-high reset
//   in_valid       fetch presents an instruction/NPC pair
//   in_ready       buffer accepts the pair this cycle
//   in_instr       fetched instruction
//   in_npc         next PC belonging to in_instr
//   flush          discard all buffered entries
//   dec_stall      decode cannot consume this cycle
//   enable_decode  Instr_dout/npc_in are valid and consumed this cycle
//   Instr_dout     head instruction (zero when empty)
//   npc_in         head NPC (zero when empty)
//   count          current number of buffered entries
// -----------------------------------------------------------------------------
module decode_in_buffer #(
  parameter int IW    = 16,
  parameter int AW    = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_instr,
  input  logic [AW-1:0] in_npc,
  input  logic          flush,
  input  logic          dec_stall,
  output logic          enable_decode,
  output logic [IW-1:0] Instr_dout,
  output logic [AW-1:0] npc_in,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [IW-1:0] instrMem [DEPTH];
  logic [AW-1:0] npcMem   [DEPTH];

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;

  logic notEmpty;
  logic notFull;
  logic push;
  logic pop;

  assign notEmpty = (count_q != '0);
  assign notFull  = (count_q != CW'(DEPTH));

  // Readiness depends only on the current occupancy, so a full buffer refuses
  // a push even when a pop frees a slot in the same cycle.
  assign in_ready      = notFull && !flush;
  assign enable_decode = notEmpty && !dec_stall && !flush;

  assign push = in_valid && in_ready;
  assign pop  = enable_decode;

  // Storage is never reset, so the head is gated by occupancy to keep the
  // outputs at zero whenever the buffer is empty.
  assign Instr_dout = notEmpty ? instrMem[rdPtr_q] : '0;
  assign npc_in     = notEmpty ? npcMem[rdPtr_q]   : '0;
  assign count      = count_q;

  // Next-state for pointers and occupancy. DEPTH is a power of two, so the
  // pointers wrap DEPTH-1 -> 0 by natural overflow of their PW-bit width.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wrPtr_d = wrPtr_q + PW'(1);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // A write during a reset cycle is harmless: the count is cleared, so the
  // entry is never presented.
  always_ff @(posedge clock) begin
    if (push) begin
      instrMem[wrPtr_q] <= in_instr;
      npcMem[wrPtr_q]   <= in_npc;
    end
  end

endmodule

// File: tb/tb_decode_in_buffer.sv
// -----------------------------------------------------------------------------
// tb_decode_in_buffer
//
// Purpose:
//   Self-checking bench for decode_in_buffer (default parameters). A table of
//   directed vectors covers the basic flow, fill under stall, full-with-pop,
//   flush, reset mid-stream and flush while empty. A hand-written stream
//   covers pointer wrap-around, and a randomized phase is compared against a
//   queue-based reference model.
// -----------------------------------------------------------------------------
module tb_decode_in_buffer;

  localparam int IW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_instr;
  logic [AW-1:0] in_npc;
  logic          flush;
  logic          dec_stall;
  logic          enable_decode;
  logic [IW-1:0] Instr_dout;
  logic [AW-1:0] npc_in;
  logic [CW-1:0] count;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: buffered {instr, npc} pairs, oldest at index 0.
  logic [IW+AW-1:0] modelQ [$];

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] instr;
    logic [AW-1:0] npc;
    logic          flush;
    logic          stall;
    logic          rst;
    logic          chk;
    logic          expReady;
    logic          expEn;
    logic [IW-1:0] expInstr;
    logic [AW-1:0] expNpc;
    logic [CW-1:0] expCount;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  decode_in_buffer #(
    .IW(IW),
    .AW(AW),
    .DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_instr(in_instr),
    .in_npc(in_npc),
    .flush(flush),
    .dec_stall(dec_stall),
    .enable_decode(enable_decode),
    .Instr_dout(Instr_dout),
    .npc_in(npc_in),
    .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(
    input logic v, input logic [IW-1:0] i, input logic [AW-1:0] n,
    input logic f, input logic s, input logic r, input logic c,
    input logic er, input logic ee, input logic [IW-1:0] ei,
    input logic [AW-1:0] en, input int ec);
    vec_t t;
    t.valid    = v;
    t.instr    = i;
    t.npc      = n;
    t.flush    = f;
    t.stall    = s;
    t.rst      = r;
    t.chk      = c;
    t.expReady = er;
    t.expEn    = ee;
    t.expInstr = ei;
    t.expNpc   = en;
    t.expCount = CW'(ec);
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Drive one cycle's inputs shortly after the rising edge and let the
  // combinational outputs settle before anything is sampled.
  task automatic applyStimulus(input logic v, input logic [IW-1:0] i,
                               input logic [AW-1:0] n, input logic f,
                               input logic s, input logic r);
    in_valid  = v;
    in_instr  = i;
    in_npc    = n;
    flush     = f;
    dec_stall = s;
    reset     = r;
    #1;
  endtask

  // Apply the buffering rules to the model for the current inputs, then let
  // the clock edge happen.
  task automatic advance();
    bit doPop;
    bit doPush;
    if (reset || flush) begin
      modelQ.delete();
    end else begin
      doPop  = (modelQ.size() != 0) && !dec_stall;
      doPush = in_valid && (modelQ.size() != DEPTH);
      if (doPop) void'(modelQ.pop_front());
      if (doPush) modelQ.push_back({in_instr, in_npc});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic checkModel();
    int sz;
    logic [IW-1:0] hi;
    logic [AW-1:0] hn;
    sz = modelQ.size();
    hi = '0;
    hn = '0;
    if (sz != 0) {hi, hn} = modelQ[0];
    checkOutput("rnd_count", 32'(count), 32'(sz));
    checkOutput("rnd_in_ready", 32'(in_ready), 32'((sz != DEPTH) && !flush));
    checkOutput("rnd_enable_decode", 32'(enable_decode),
                32'((sz != 0) && !dec_stall && !flush));
    checkOutput("rnd_Instr_dout", 32'(Instr_dout), 32'(hi));
    checkOutput("rnd_npc_in", 32'(npc_in), 32'(hn));
  endtask

  initial begin
    // Directed vectors; expected outputs are those seen during the cycle
    // (before the edge at which the inputs take effect).
    // Basic flow.
    vecs[0]  = mk(1, 16'h1234, 16'h3001, 0, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0);
    vecs[1]  = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 1, 16'h1234, 16'h3001, 1);
    vecs[2]  = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0);
    // Fill under stall: five pushes, the fifth refused, then drain in order.
    vecs[3]  = mk(1, 16'h1001, 16'h2001, 0, 1, 0, 1, 1, 0, 16'h0000, 16'h0000, 0);
    vecs[4]  = mk(1, 16'h1002, 16'h2002, 0, 1, 0, 1, 1, 0, 16'h1001, 16'h2001, 1);
    vecs[5]  = mk(1, 16'h1003, 16'h2003, 0, 1, 0, 1, 1, 0, 16'h1001, 16'h2001, 2);
    vecs[6]  = mk(1, 16'h1004, 16'h2004, 0, 1, 0, 1, 1, 0, 16'h1001, 16'h2001, 3);
    vecs[7]  = mk(1, 16'h1005, 16'h2005, 0, 1, 0, 1, 0, 0, 16'h1001, 16'h2001, 4);
    vecs[8]  = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 1, 16'h1001, 16'h2001, 4);
    vecs[9]  = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 1, 16'h1002, 16'h2002, 3);
    vecs[10] = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 1, 16'h1003, 16'h2003, 2);
    vecs[11] = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 1, 16'h1004, 16'h2004, 1);
    vecs[12] = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0);
    // Full with pop: push refused while full, accepted next cycle.
    vecs[13] = mk(1, 16'h3101, 16'h5101, 0, 1, 0, 1, 1, 0, 16'h0000, 16'h0000, 0);
    vecs[14] = mk(1, 16'h3102, 16'h5102, 0, 1, 0, 1, 1, 0, 16'h3101, 16'h5101, 1);
    vecs[15] = mk(1, 16'h3103, 16'h5103, 0, 1, 0, 1, 1, 0, 16'h3101, 16'h5101, 2);
    vecs[16] = mk(1, 16'h3104, 16'h5104, 0, 1, 0, 1, 1, 0, 16'h3101, 16'h5101, 3);
    vecs[17] = mk(1, 16'h3105, 16'h5105, 0, 0, 0, 1, 0, 1, 16'h3101, 16'h5101, 4);
    vecs[18] = mk(1, 16'h3105, 16'h5105, 0, 0, 0, 1, 1, 1, 16'h3102, 16'h5102, 3);
    vecs[19] = mk(0, 16'h0000, 16'h0000, 0, 1, 0, 1, 1, 0, 16'h3103, 16'h5103, 3);
    // Flush with count=3 and a same-cycle push; next push is first out.
    vecs[20] = mk(1, 16'h7777, 16'h7778, 1, 0, 0, 1, 0, 0, 16'h3103, 16'h5103, 3);
    vecs[21] = mk(1, 16'hABCD, 16'h4000, 0, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0);
    vecs[22] = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 1, 16'hABCD, 16'h4000, 1);
    vecs[23] = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0);
    // Reset mid-stream with two entries buffered.
    vecs[24] = mk(1, 16'h0D01, 16'h0E01, 0, 1, 0, 1, 1, 0, 16'h0000, 16'h0000, 0);
    vecs[25] = mk(1, 16'h0D02, 16'h0E02, 0, 1, 0, 1, 1, 0, 16'h0D01, 16'h0E01, 1);
    vecs[26] = mk(1, 16'h0D03, 16'h0E03, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0);
    vecs[27] = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0);
    // Flush while empty, with a valid input that must be dropped.
    vecs[28] = mk(1, 16'h0F0F, 16'h0F0F, 1, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0);
    vecs[29] = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0);

    // Reset for two edges, then check the reset state.
    applyStimulus(0, '0, '0, 0, 0, 1);
    advance();
    advance();
    applyStimulus(0, '0, '0, 0, 0, 0);
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_enable_decode", 32'(enable_decode), 32'd0);
    checkOutput("reset_Instr_dout", 32'(Instr_dout), 32'd0);
    checkOutput("reset_npc_in", 32'(npc_in), 32'd0);

    $display("[TB] directed vectors");
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].instr, vecs[i].npc,
                    vecs[i].flush, vecs[i].stall, vecs[i].rst);
      if (vecs[i].chk) begin
        checkOutput($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].expCount));
        checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].expReady));
        checkOutput($sformatf("vec%0d_enable_decode", i), 32'(enable_decode), 32'(vecs[i].expEn));
        checkOutput($sformatf("vec%0d_Instr_dout", i), 32'(Instr_dout), 32'(vecs[i].expInstr));
        checkOutput($sformatf("vec%0d_npc_in", i), 32'(npc_in), 32'(vecs[i].expNpc));
      end
      advance();
    end

    // Wrap-around: ten pairs at one per cycle, each emerging one cycle later.
    $display("[TB] wrap-around stream");
    for (int i = 0; i <= 10; i++) begin
      applyStimulus(i < 10, IW'(16'h6000 + i), AW'(16'h8000 + i), 0, 0, 0);
      if (i > 0) begin
        checkOutput($sformatf("wrap%0d_count", i), 32'(count), 32'd1);
        checkOutput($sformatf("wrap%0d_enable_decode", i), 32'(enable_decode), 32'd1);
        checkOutput($sformatf("wrap%0d_Instr_dout", i), 32'(Instr_dout), 32'(16'h6000 + i - 1));
        checkOutput($sformatf("wrap%0d_npc_in", i), 32'(npc_in), 32'(16'h8000 + i - 1));
      end
      advance();
    end
    applyStimulus(0, '0, '0, 0, 0, 0);
    checkOutput("wrap_end_count", 32'(count), 32'd0);

    // Randomized traffic against the reference model.
    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 99) < 70, IW'($urandom), AW'($urandom),
                    $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 35,
                    $urandom_range(0, 99) < 2);
      if (!reset) checkModel();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/decode_in_buffer.md
DECODE_IN_BUFFER -- requirements
Module: decode_in_buffer

Interface
REQ-001 The module SHALL have parameter IW, default 16, instruction width in bits.
REQ-002 The module SHALL have parameter AW, default 16, NPC width in bits.
REQ-003 The module SHALL have parameter DEPTH, default 4, number of entries; a power of 2, minimum 2.
REQ-004 The module SHALL have parameter CW = $clog2(DEPTH+1), derived, occupancy count width.
REQ-005 Port: clock  input  1  sole clock; all state updates on the rising edge.
REQ-006 Port: reset  input  1  synchronous, active-high reset.
REQ-007 Port: in_valid  input  1  fetch presents an instruction/NPC pair.
REQ-008 Port: in_ready  output  1  buffer accepts the pair this cycle.
REQ-009 Port: in_instr  input  IW  fetched instruction.
REQ-010 Port: in_npc  input  AW  next PC belonging to in_instr.
REQ-011 Port: flush  input  1  branch/redirect; discard all buffered entries.
REQ-012 Port: dec_stall  input  1  decode stage cannot consume this cycle.
REQ-013 Port: enable_decode  output  1  Instr_dout/npc_in are valid and consumed this cycle.
REQ-014 Port: Instr_dout  output  IW  head instruction to decode.
REQ-015 Port: npc_in  output  AW  head NPC to decode.
REQ-016 Port: count  output  CW  current number of buffered entries.

Function
REQ-017 Storage SHALL be a circular FIFO of DEPTH entries, each holding {instr, npc}, with write pointer, read pointer and occupancy counter.
REQ-018 in_ready SHALL equal (count != DEPTH) && !flush, combinationally.
REQ-019 Push SHALL occur when in_valid && in_ready; the entry is written at the write pointer, and the write pointer advances modulo DEPTH.
REQ-020 enable_decode SHALL equal (count != 0) && !dec_stall && !flush, combinationally.
REQ-021 Pop SHALL occur when enable_decode is 1; the read pointer advances modulo DEPTH.
REQ-022 Instr_dout/npc_in SHALL present the head entry whenever count != 0, and SHALL be all zeros when count == 0.
REQ-023 Latency: a pair pushed in cycle N SHALL be presented no earlier than cycle N+1; there is no empty-bypass path.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and move both pointers.
REQ-025 When full, push SHALL be refused even if a pop occurs in the same cycle.
REQ-026 Flush SHALL have priority over push and pop: the next cycle has count=0 and both pointers equal, and the same-cycle input is dropped.
REQ-027 Flush asserted while empty SHALL be harmless; it leaves no state change beyond pointer equalisation.
REQ-028 dec_stall SHALL hold the head entry and outputs stable; push continues until full.
REQ-029 count SHALL never exceed DEPTH or wrap below 0; pointers SHALL wrap DEPTH-1 -> 0.
REQ-030 The behaviour of in_instr/in_npc when in_valid=0 SHALL be don't-care; those inputs are never stored.

Reset
REQ-031 While reset=1 at a clock edge, count, both pointers and all state SHALL clear to 0.
REQ-032 During and after reset: in_ready=1 (flush=0), enable_decode=0, Instr_dout=0, npc_in=0, count=0.
REQ-033 Reset mid-operation SHALL discard all entries, including any push or pop in the reset cycle.
REQ-034 Storage array contents need not be reset; outputs are gated by count.

Verification
REQ-035 Basic flow: after reset, push {0x1234,0x3001} with dec_stall=0 -> next cycle enable_decode=1, Instr_dout=0x1234, npc_in=0x3001; following cycle count=0 and outputs are 0.
REQ-036 Fill under stall: hold dec_stall=1 and push 5 pairs with DEPTH=4 -> in_ready=0 after 4 pushes, count=4, and the 5th pair is not stored; release the stall -> pairs 1..4 emerge in order on 4 consecutive cycles.
REQ-037 Full with pop: count=4, dec_stall=0, in_valid=1 -> pop occurs, push is refused, count=3; the next cycle's push is accepted.
REQ-038 Flush: count=3 and flush=1 with in_valid=1 -> same cycle enable_decode=0, in_ready=0; next cycle count=0, then new push {0xABCD,0x4000} is the first output.
REQ-039 Wrap-around: stream 10 pairs at one per cycle with no stall -> count holds at 1, and the outputs match the input order across two pointer wraps.
REQ-040 Reset mid-stream: count=2 and reset=1 for one cycle -> next cycle count=0, enable_decode=0, Instr_dout=0.
